// File: rtl/wrsel_pkg.sv
// Shared encodings for the lane-steering store unit: access sizes and FSM states.
package wrsel_pkg;

  localparam logic [1:0] SIZE_B   = 2'd0;
  localparam logic [1:0] SIZE_H   = 2'd1;
  localparam logic [1:0] SIZE_W   = 2'd2;
  localparam logic [1:0] SIZE_ILL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

endpackage

// File: rtl/wrselb_lane.sv
// Byte-lane steering for a right-justified store: enables and data for the
// lower word beat and the spill-over beat, plus split detection.
module wrselb_lane
  import wrsel_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic        split_o
);

  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [63:0] data_wide;

  always_comb begin
    mask = 4'b0001;
    case (size_i)
      SIZE_H:  mask = 4'b0011;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0001;
    endcase
    be_wide   = {4'b0000, mask} << off_i;
    data_wide = {32'h0, data_i} << {off_i, 3'b000};
    be0_o     = be_wide[3:0];
    be1_o     = be_wide[7:4];
    split_o   = |be_wide[7:4];
    // Disabled lanes carry zero so stray upper data bytes never leak onto the bus.
    for (int i = 0; i < 4; i++) begin
      wdata0_o[8*i +: 8] = be_wide[i]     ? data_wide[8*i +: 8]      : 8'h00;
      wdata1_o[8*i +: 8] = be_wide[4 + i] ? data_wide[32 + 8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/wrsel_store.sv
// Store unit: accepts one sub-word/word store at a time and issues one or two
// aligned write beats with byte enables.
module wrsel_store
  import wrsel_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic              accept;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        be0, be1;
  logic [31:0]       wdata0, wdata1;
  logic              split;

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

  wrselb_lane u_lane (
    .off_i    (addr_q[1:0]),
    .size_i   (size_q),
    .data_i   (data_q),
    .be0_o    (be0),
    .be1_o    (be1),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1),
    .split_o  (split)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture happens only in IDLE, so beat outputs hold through stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      size_q <= SIZE_B;
      data_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && (req_size == SIZE_ILL);
      if (accept) begin
        addr_q <= req_addr;
        size_q <= req_size;
        data_q <= req_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_valid && (req_size != SIZE_ILL)) state_d = ST_BEAT0;
      ST_BEAT0: if (mem_ready) state_d = split ? ST_BEAT1 : ST_IDLE;
      ST_BEAT1: if (mem_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    err       = err_q;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    unique case (state_q)
      ST_BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = base_addr;
        mem_be    = be0;
        mem_wdata = wdata0;
      end
      ST_BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = base_addr + ADDR_W'(4);
        mem_be    = be1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wrsel_store.sv
// Directed self-checking bench for wrsel_store with hand-computed beat values.
module tb_wrsel_store;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        err;

  int checks = 0;
  int errors = 0;

  wrsel_store #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns at the next falling edge.
  task automatic send(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    chk("req_ready_before_send", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_data  = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd1);
    chk({tag, "_addr"},  64'(mem_addr),  64'(a));
    chk({tag, "_be"},    64'(mem_be),    64'(be));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wd));
    chk({tag, "_rdy"},   64'(req_ready), 64'd0);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_rdy"},   64'(req_ready), 64'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_size  = 2'd0;
    req_data  = 32'h0;
    mem_ready = 1'b0;

    #3;
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_addr",  64'(mem_addr),  64'd0);
    chk("rst_be",    64'(mem_be),    64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_err",   64'(err),       64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_idle("post_rst");

    // mem_ready while nothing is pending must not create a beat
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    expect_idle("idle_ready");

    send(32'h0000_1002, 2'd0, 32'h0000_00AB);
    expect_beat("b1002", 32'h0000_1000, 4'b0100, 32'h00AB_0000);
    @(negedge clk);
    expect_idle("b1002_done");

    send(32'h0000_0010, 2'd0, 32'hDEAD_BEEF);
    expect_beat("bzero", 32'h0000_0010, 4'b0001, 32'h0000_00EF);
    @(negedge clk);
    expect_idle("bzero_done");

    send(32'h0000_3001, 2'd1, 32'h0000_BEEF);
    expect_beat("h3001", 32'h0000_3000, 4'b0110, 32'h00BE_EF00);
    @(negedge clk);
    expect_idle("h3001_done");

    send(32'h0000_4000, 2'd2, 32'h1234_5678);
    expect_beat("w4000", 32'h0000_4000, 4'b1111, 32'h1234_5678);
    @(negedge clk);
    expect_idle("w4000_done");

    send(32'h0000_2001, 2'd2, 32'h788E_FD0C);
    expect_beat("w2001_b0", 32'h0000_2000, 4'b1110, 32'h8EFD_0C00);
    @(negedge clk);
    expect_beat("w2001_b1", 32'h0000_2004, 4'b0001, 32'h0000_0078);
    @(negedge clk);
    expect_idle("w2001_done");

    // Stalled split half-word: each beat must hold for three cycles
    mem_ready = 1'b0;
    send(32'h0000_3003, 2'd1, 32'h0000_BEEF);
    for (int i = 0; i < 3; i++) begin
      expect_beat("h3003_b0", 32'h0000_3000, 4'b1000, 32'hEF00_0000);
      if (i < 2) @(negedge clk);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      expect_beat("h3003_b1", 32'h0000_3004, 4'b0001, 32'h0000_00BE);
      if (i < 2) @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    expect_idle("h3003_done");

    send(32'hFFFF_FFFE, 2'd2, 32'h1122_3344);
    expect_beat("wwrap_b0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    @(negedge clk);
    expect_beat("wwrap_b1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    @(negedge clk);
    expect_idle("wwrap_done");

    send(32'h0000_5000, 2'd3, 32'hCAFE_F00D);
    chk("ill_err",   64'(err),       64'd1);
    chk("ill_valid", 64'(mem_valid), 64'd0);
    chk("ill_rdy",   64'(req_ready), 64'd1);
    @(negedge clk);
    chk("ill_err_clr",  64'(err),       64'd0);
    chk("ill_valid2",   64'(mem_valid), 64'd0);
    send(32'h0000_5003, 2'd0, 32'h0000_0077);
    expect_beat("after_ill", 32'h0000_5000, 4'b1000, 32'h7700_0000);
    chk("after_ill_err", 64'(err), 64'd0);
    @(negedge clk);
    expect_idle("after_ill_done");

    // Reset in the middle of a split store abandons the second beat
    send(32'h0000_2001, 2'd2, 32'h788E_FD0C);
    expect_beat("rst_b0", 32'h0000_2000, 4'b1110, 32'h8EFD_0C00);
    @(negedge clk);
    expect_beat("rst_b1", 32'h0000_2004, 4'b0001, 32'h0000_0078);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(mem_valid), 64'd0);
    chk("midrst_addr",  64'(mem_addr),  64'd0);
    chk("midrst_be",    64'(mem_be),    64'd0);
    chk("midrst_wdata", 64'(mem_wdata), 64'd0);
    chk("midrst_err",   64'(err),       64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_idle("midrst_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrsel_store.md
WRSEL_STORE -- requirements
Module: wrsel_store

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width (minimum 3).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, store request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-007 SHALL have port req_size, input, 2, encoding 0=byte, 1=halfword, 2=word, 3=illegal.
REQ-008 SHALL have port req_data, input, 32, store data, right-justified.
REQ-009 SHALL have port mem_valid, output, 1, write beat present.
REQ-010 SHALL have port mem_ready, input, 1, beat consumed when mem_valid && mem_ready.
REQ-011 SHALL have port mem_addr, output, ADDR_W, word-aligned address; bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata, output, 32, lane-steered write data.
REQ-013 SHALL have port mem_be, output, 4, byte enables, bit i = byte lane i, little-endian.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on illegal request.

Function
REQ-015 SHALL implement FSM states IDLE, BEAT0, BEAT1.
REQ-016 SHALL assert req_ready only in IDLE; no request accepted while a store is in flight.
REQ-017 On acceptance, SHALL register addr/size/data and enter BEAT0; mem_valid asserted the following cycle (latency 1).
REQ-018 Let off = addr[1:0], mask = 4'b0001/0011/1111 for byte/half/word; BEAT0 SHALL drive mem_addr = {addr[ADDR_W-1:2],2'b00}, mem_be = (mask<<off)[3:0], mem_wdata = (data<<(8*off))[31:0].
REQ-019 Request SHALL be split when (mask<<off) has any bit in [7:4]: byte never; half at off=3; word at off 1..3.
REQ-020 BEAT1 SHALL drive mem_addr = BEAT0 address + 4 (modulo 2^ADDR_W, wraps to 0), mem_be = (mask<<off)[7:4], mem_wdata = data>>(8*(4-off)).
REQ-021 mem_valid, mem_addr, mem_wdata, mem_be SHALL remain stable while mem_valid && !mem_ready.
REQ-022 BEAT0 with mem_ready: unsplit -> IDLE, split -> BEAT1; BEAT1 with mem_ready -> IDLE.
REQ-023 Lanes with mem_be bit 0 SHALL drive mem_wdata byte 0x00.
REQ-024 size=3 request SHALL be accepted, produce no beat, pulse err the cycle after acceptance, stay in IDLE.
REQ-025 Return to IDLE SHALL assert req_ready in the same cycle the last beat completes is NOT allowed; req_ready rises the cycle after (registered state).
REQ-026 mem_ready asserted while mem_valid low SHALL be ignored.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE, mem_valid=0, mem_be=0, mem_addr=0, mem_wdata=0, err=0; req_ready=1 after release.
REQ-028 Reset mid-store (BEAT0 or BEAT1) SHALL abandon the store; no further beats after release.

Structure
REQ-029 Shared package wrsel_pkg SHALL hold size encodings (SIZE_B, SIZE_H, SIZE_W) and FSM state encodings.
REQ-030 Combinational lane steering (mask, shift, split detect) SHALL be sub-module wrselb_lane; wrsel_store holds FSM and registers.

Verification
REQ-031 Byte store addr=0x1002 data=0x000000AB, mem_ready=1 -> one beat addr 0x1000, be 0100, wdata 0x00AB0000.
REQ-032 Word store addr=0x2001 data=0x788EFD0C -> beat0 addr 0x2000 be 1110 wdata 0x8EFD0C00; beat1 addr 0x2004 be 0001 wdata 0x00000078.
REQ-033 Half store addr=0x3003 data=0x0000BEEF, mem_ready low 3 cycles in each beat -> beat0 be 1000 wdata 0xEF000000 held stable, beat1 addr 0x3004 be 0001 wdata 0x000000BE; req_ready low throughout.
REQ-034 Word store addr=0xFFFFFFFE data=0x11223344 -> beat0 addr 0xFFFFFFFC be 1100 wdata 0x33440000; beat1 addr 0x00000000 be 0011 wdata 0x00001122.
REQ-035 req_size=3 -> err one-cycle pulse, mem_valid never asserted, next request accepted normally.
REQ-036 reset_n pulsed low during BEAT1 of REQ-032 -> mem_valid drops immediately, outputs zero, no beat after release.
